// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader. It receives a framed byte stream over a valid/ready
// handshake, assembles big-endian 32-bit words and writes them to consecutive
// word addresses of the instruction RAM. The core is held in reset until a
// frame has been loaded and its XOR checksum verified.
//
// Frame: N[15:8], N[7:0], 4*N payload bytes (MSB first per word), checksum
// byte (XOR of payload bytes only, seeded with 0x00).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   start      in   restart request, honoured only in DONE or ERR
//   in_valid   in   in_byte carries a byte
//   in_byte    in   stream byte [7:0]
//   in_ready   out  loader can take a byte (combinational from state)
//   im_we      out  instruction RAM write strobe, one cycle per word
//   im_addr    out  instruction RAM word address [ADDR_W-1:0]
//   im_wd      out  instruction RAM write data [31:0]
//   cpu_reset  out  active-high core reset, low only after a good load
//   done       out  load succeeded (level)
//   error      out  load failed (level)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wd,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  // State encoding kept as plain constants so the register can be probed and
  // compared against numeric values in older tooling.
  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Largest legal word count; one bit wider than a 16-bit N so that
  // 2**ADDR_W itself is representable for any ADDR_W up to 15.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]        state_q,    state_d;
  logic [7:0]        n_hi_q,     n_hi_d;      // N[15:8], held until HDR1
  logic [ADDR_W:0]   n_q,        n_d;         // validated N, fits after HDR1
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;  // words written so far
  logic [1:0]        byte_cnt_q, byte_cnt_d;  // byte position within word
  logic [23:0]       word_q,     word_d;      // first three bytes of a word
  logic [7:0]        csum_q,     csum_d;
  logic              im_we_q,    im_we_d;
  logic [ADDR_W-1:0] im_addr_q,  im_addr_d;
  logic [31:0]       im_wd_q,    im_wd_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q,     done_d;
  logic              error_q,    error_d;

  logic              accept;
  logic [15:0]       n_full;
  logic [ADDR_W:0]   word_cnt_inc;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // in_ready is combinational so a byte can be taken every cycle. Gating with
  // the reset input keeps it low during reset regardless of the state value.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      case (state_q)
        S_HDR0, S_HDR1, S_DATA, S_CHK: in_ready = 1'b1;
        default:                       in_ready = 1'b0;
      endcase
    end
  end

  assign accept       = in_valid & in_ready;
  assign n_full       = {n_hi_q, in_byte};
  assign word_cnt_inc = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    n_hi_d     = n_hi_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wd_d    = im_wd_q;

    case (state_q)
      S_HDR0: begin
        if (accept) begin
          n_hi_d  = in_byte;
          state_d = S_HDR1;
        end
      end

      S_HDR1: begin
        if (accept) begin
          n_d = n_full[ADDR_W:0];
          if ({1'b0, n_full} > MAX_WORDS) begin
            state_d = S_ERR;
          end else if (n_full == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {word_q[15:0], in_byte};
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes the word: write it at the running index.
            im_we_d    = 1'b1;
            im_addr_d  = word_cnt_q[ADDR_W-1:0];
            im_wd_d    = {word_q, in_byte};
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == n_q) begin
              state_d = S_CHK;
            end
          end
        end
      end

      S_CHK: begin
        if (accept) begin
          state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
        end
      end

      S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR0;
          csum_d     = 8'h00;
          word_cnt_d = '0;
          byte_cnt_d = 2'd0;
        end
      end

      default: begin
        // Unreachable encodings fall back to a clean frame start.
        state_d    = S_HDR0;
        csum_d     = 8'h00;
        word_cnt_d = '0;
        byte_cnt_d = 2'd0;
      end
    endcase

    // Status outputs are registered copies of where the FSM is heading, so
    // they change in the same cycle the state does.
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
    cpu_reset_d = (state_d != S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HDR0;
      n_hi_q      <= 8'h00;
      n_q         <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= 2'd0;
      word_q      <= 24'h000000;
      csum_q      <= 8'h00;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wd_q     <= 32'h0000_0000;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_hi_q      <= n_hi_d;
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wd_q     <= im_wd_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wd     = im_wd_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader (ADDR_W = 6). Inputs change on the falling
// edge, the DUT samples on the rising edge and outputs are observed on the
// following falling edge. A monitor logs every write strobe so pulse count,
// addresses and data can be compared against the hand-built frames.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wd;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  tx[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wd     (im_wd),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Write log: one entry per cycle the strobe is high.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_addr.push_back(32'(im_addr));
      wr_data.push_back(im_wd);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called and returns on a falling edge; the byte is transferred on the
  // rising edge in between, so back-to-back calls give one byte per cycle.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'hxx;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Sends tx[]; optional random gaps of 0..max_gap cycles before each byte.
  task automatic send_frame(input int max_gap);
    foreach (tx[i]) begin
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
      send_byte(tx[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_nominal(input logic [7:0] cs);
    tx.delete();
    tx.push_back(8'h00); tx.push_back(8'h02);
    tx.push_back(8'h20); tx.push_back(8'h02); tx.push_back(8'h00); tx.push_back(8'h05);
    tx.push_back(8'h20); tx.push_back(8'h03); tx.push_back(8'h00); tx.push_back(8'h0c);
    tx.push_back(cs);
  endtask

  task automatic check_nominal_writes(input string tag);
    check({tag, "_wcount"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      check({tag, "_a0"}, wr_addr[0], 32'd0);
      check({tag, "_d0"}, wr_data[0], 32'h2002_0005);
      check({tag, "_a1"}, wr_addr[1], 32'd1);
      check({tag, "_d1"}, wr_data[1], 32'h2003_000c);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    logic [7:0] b0, b1, b2, b3, cs;

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    // ---- Reset values ------------------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_im_we",     {31'd0, im_we},     32'd0);
    check("rst_im_addr",   32'(im_addr),       32'd0);
    check("rst_im_wd",     im_wd,              32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_error",     {31'd0, error},     32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // ---- Nominal load, stepwise write timing --------------------------------
    clear_log();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    check("nom_we0",   {31'd0, im_we}, 32'd1);
    check("nom_addr0", 32'(im_addr),   32'd0);
    check("nom_wd0",   im_wd,          32'h2002_0005);
    send_byte(8'h20);
    check("nom_we_one_cycle", {31'd0, im_we}, 32'd0);
    check("nom_wd_hold",      im_wd,          32'h2002_0005);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h0c);
    check("nom_we1",   {31'd0, im_we}, 32'd1);
    check("nom_addr1", 32'(im_addr),   32'd1);
    check("nom_cpu_reset_before_chk", {31'd0, cpu_reset}, 32'd1);
    send_byte(8'h08);
    check("nom_done",      {31'd0, done},      32'd1);
    check("nom_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("nom_error",     {31'd0, error},     32'd0);
    check("nom_ready",     {31'd0, in_ready},  32'd0);
    check_nominal_writes("nom");

    // Bytes offered in DONE are not consumed and change nothing.
    in_valid = 1'b1;
    in_byte  = 8'haa;
    repeat (3) @(negedge clk);
    check("done_hold_ready", {31'd0, in_ready}, 32'd0);
    check("done_hold_done",  {31'd0, done},     32'd1);
    check("done_hold_wr",    32'(wr_addr.size()), 32'd2);
    in_valid = 1'b0;

    // Restart from DONE.
    pulse_start();
    check("rs_done_ready",     {31'd0, in_ready},  32'd1);
    check("rs_done_done",      {31'd0, done},      32'd0);
    check("rs_done_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // ---- Bad checksum -------------------------------------------------------
    clear_log();
    load_nominal(8'h09);
    send_frame(0);
    check("bad_error",     {31'd0, error},     32'd1);
    check("bad_done",      {31'd0, done},      32'd0);
    check("bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("bad_ready",     {31'd0, in_ready},  32'd0);
    check_nominal_writes("bad");
    idle(2);
    check("bad_error_level", {31'd0, error}, 32'd1);

    // Restart from ERR.
    pulse_start();
    check("rs_err_ready", {31'd0, in_ready}, 32'd1);
    check("rs_err_error", {31'd0, error},    32'd0);

    // ---- N = 0x41: overflow on second header byte ---------------------------
    clear_log();
    send_byte(8'h00);
    check("ovf_no_error_yet", {31'd0, error}, 32'd0);
    send_byte(8'h41);
    check("ovf_error",     {31'd0, error},       32'd1);
    check("ovf_cpu_reset", {31'd0, cpu_reset},   32'd1);
    idle(2);
    check("ovf_no_write",  32'(wr_addr.size()),  32'd0);
    pulse_start();

    // ---- N = 0, checksum 00 -------------------------------------------------
    clear_log();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("n0_done",      {31'd0, done},      32'd1);
    check("n0_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("n0_no_write",  32'(wr_addr.size()), 32'd0);
    pulse_start();

    // ---- N = 0x40: full memory ----------------------------------------------
    clear_log();
    cs = 8'h00;
    send_byte(8'h00); send_byte(8'h40);
    for (int k = 0; k < 64; k++) begin
      b0 = 8'(k);
      b1 = 8'(k) ^ 8'h5a;
      b2 = ~8'(k);
      b3 = 8'(k) + 8'h11;
      cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
      send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    end
    check("max_not_done_before_chk", {31'd0, done}, 32'd0);
    send_byte(cs);
    check("max_done",   {31'd0, done},        32'd1);
    check("max_wcount", 32'(wr_addr.size()),  32'd64);
    if (wr_addr.size() == 64) begin
      for (int k = 0; k < 64; k++) begin
        b0 = 8'(k);
        b1 = 8'(k) ^ 8'h5a;
        b2 = ~8'(k);
        b3 = 8'(k) + 8'h11;
        check($sformatf("max_addr%0d", k), wr_addr[k], 32'(k));
        check($sformatf("max_data%0d", k), wr_data[k], {b0, b1, b2, b3});
      end
    end
    pulse_start();

    // ---- Gaps in in_valid, plus an ignored start during DATA ----------------
    clear_log();
    load_nominal(8'h08);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(2, 0));
      send_byte(tx[i]);
    end
    start = 1'b1;
    idle(1);
    start = 1'b0;
    check("start_in_data_ready", {31'd0, in_ready}, 32'd1);
    check("start_in_data_error", {31'd0, error},    32'd0);
    for (int i = 4; i < 11; i++) begin
      idle($urandom_range(3, 0));
      send_byte(tx[i]);
    end
    check("gap_done",      {31'd0, done},      32'd1);
    check("gap_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check_nominal_writes("gap");
    pulse_start();

    // ---- Asynchronous reset mid-frame ---------------------------------------
    clear_log();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h00);
    reset = 1'b0;
    #1;
    check("mid_rst_ready",     {31'd0, in_ready},  32'd0);
    check("mid_rst_we",        {31'd0, im_we},     32'd0);
    check("mid_rst_addr",      32'(im_addr),       32'd0);
    check("mid_rst_wd",        im_wd,              32'd0);
    check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("mid_rst_done",      {31'd0, done},      32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    load_nominal(8'h08);
    send_frame(0);
    check("replay_done",      {31'd0, done},      32'd1);
    check("replay_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check_nominal_writes("replay");

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
